jt6295_tgen: RTL

Parametrised sample-timing generator for the JT6295 ADPCM core: derives sample-rate, 4x-sample-rate and per-channel slot strobes from the chip clock-enable. It extends the fixed two-rate divider with selectable fixed rates, a programmable divider and a halt mode. It also adds a configurable channel count, a free-running sample counter and glitch-free rate changes applied only at sample boundaries. It sits between the top-level clock-enable input and the ADPCM decoder/channel sequencer.

---
 rtl/jt6295_tgen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/jt6295_tgen.sv
// jt6295_tgen: sample-timing generator for the JT6295 ADPCM core.
// Produces the sample strobe, the four quarter strobes and the per-channel
// slot strobes from the chip clock-enable. The rate comes from a fixed table,
// a programmable quarter length, or halt. A new rate is only taken at a
// sample boundary, so a rate change never produces a partial period.
module jt6295_tgen #(
    parameter  int CHANNELS = 4,
    parameter  int QW       = 8,
    parameter  int CNTW     = 16,
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [1:0]      mode,
    input  logic [QW-1:0]   qlen,
    output logic            cen_sr,
    output logic            cen_sr4,
    output logic [1:0]      phase,
    output logic            ch_cen,
    output logic [CHW-1:0]  ch_idx,
    output logic [CNTW-1:0] sr_cnt
);

    // The quarter counter must hold the fixed lengths (up to 41) even when
    // the programmable input is narrower than that.
    localparam int QCW = (QW > 6) ? QW : 6;
    localparam logic [QCW-1:0] QMIN    = QCW'(CHANNELS + 1);
    localparam logic [QCW-1:0] CH_LAST = QCW'(CHANNELS);
    localparam logic [QCW-1:0] QONE    = QCW'(1);
    localparam logic [QCW-1:0] QZERO   = '0;

    // Effective quarter length for a running mode. Programmable lengths are
    // clamped so every channel slot fits inside quarter 0.
    function automatic logic [QCW-1:0] eff_q(input logic [1:0] m, input logic [QW-1:0] ql);
        logic [QCW-1:0] ext;
        ext = QCW'(ql);
        case (m)
            2'd0:    eff_q = QCW'(41);
            2'd1:    eff_q = QCW'(33);
            default: eff_q = (ext < QMIN) ? QMIN : ext;
        endcase
    endfunction

    logic [QCW-1:0]  qcnt, qcnt_nx;
    logic [1:0]      ph, ph_nx;
    logic [1:0]      amode, amode_nx;
    logic [QCW-1:0]  q, q_nx;
    logic [QCW-1:0]  run_q;
    logic            run;
    logic            sr_nx, sr4_nx, ch_nx;
    logic [CHW-1:0]  idx_nx;
    logic [1:0]      phase_nx;
    logic [CNTW-1:0] cnt_nx;

    // Register all timing state and the strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qcnt    <= QZERO;
            ph      <= 2'd0;
            amode   <= 2'd0;
            q       <= QCW'(41);
            cen_sr  <= 1'b0;
            cen_sr4 <= 1'b0;
            ch_cen  <= 1'b0;
            ch_idx  <= '0;
            phase   <= 2'd0;
            sr_cnt  <= '0;
        end else begin
            qcnt    <= qcnt_nx;
            ph      <= ph_nx;
            amode   <= amode_nx;
            q       <= q_nx;
            cen_sr  <= sr_nx;
            cen_sr4 <= sr4_nx;
            ch_cen  <= ch_nx;
            ch_idx  <= idx_nx;
            phase   <= phase_nx;
            sr_cnt  <= cnt_nx;
        end
    end

    // Next-state: sample the configuration at the boundary, emit strobes and
    // advance the quarter counter on every enabled tick.
    always_comb begin
        qcnt_nx  = qcnt;
        ph_nx    = ph;
        amode_nx = amode;
        q_nx     = q;
        run_q    = q;
        run      = 1'b0;
        sr_nx    = 1'b0;
        sr4_nx   = 1'b0;
        ch_nx    = 1'b0;
        idx_nx   = ch_idx;
        phase_nx = phase;
        cnt_nx   = sr_cnt;
        if (cen) begin
            if (qcnt == QZERO && ph == 2'd0) begin
                // Halt parks the counters here, so mode is re-sampled on
                // every enabled tick while halted.
                amode_nx = mode;
                if (mode != 2'd3) begin
                    q_nx  = eff_q(mode, qlen);
                    run_q = q_nx;
                    run   = 1'b1;
                end
            end else begin
                run = 1'b1;
            end
            if (run) begin
                if (qcnt == QZERO) begin
                    sr4_nx   = 1'b1;
                    phase_nx = ph;
                    if (ph == 2'd0) begin
                        sr_nx  = 1'b1;
                        cnt_nx = sr_cnt + CNTW'(1);
                    end
                end
                if (ph == 2'd0 && qcnt >= QONE && qcnt <= CH_LAST) begin
                    ch_nx  = 1'b1;
                    idx_nx = CHW'(qcnt - QONE);
                end
                if (qcnt == run_q - QONE) begin
                    qcnt_nx = QZERO;
                    ph_nx   = ph + 2'd1;
                end else begin
                    qcnt_nx = qcnt + QONE;
                end
            end
        end
    end

endmodule
